// File: rtl/y_signature_compactor.sv
// ---------------------------------------------------------------------------
// y_signature_compactor
//
// Compresses the DUT output word `y` into a SIG_W-bit multiple-input
// signature register (MISR).  A capture starts on `start`, folds in one word
// per cycle with `sample_en`, and ends on `stop` or after N_SAMPLES accepted
// samples.  The final signature and the sample count are then offered to
// the run checker through a valid/ready handshake.
//
// Ports
//   clk         sampling clock, rising edge active
//   rst         synchronous active-high reset
//   start       load SEED, clear count, enter RUN (restarts when in RUN)
//   sample_en   qualifies `y` this cycle
//   y           DUT output word, IN_W bits
//   stop        end capture early
//   sig_out     final signature, SIG_W bits
//   sample_cnt  accepted samples, CNT_W bits, saturating
//   sig_valid   sig_out / sample_cnt hold a result
//   sig_ready   consumer accepts the result
//   busy        high while capturing (RUN)
// ---------------------------------------------------------------------------
module y_signature_compactor #(
  parameter int                IN_W      = 481,
  parameter int                SIG_W     = 32,
  parameter logic [SIG_W-1:0]  POLY      = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED      = 32'hFFFFFFFF,
  parameter int                N_SAMPLES = 21,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_en,
  input  logic [IN_W-1:0]   y,
  input  logic              stop,
  output logic [SIG_W-1:0]  sig_out,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of SIG_W chunks after zero-padding y up to a whole chunk.
  localparam int NCHUNK = (IN_W + SIG_W - 1) / SIG_W;

  state_t             state_reg, state_next;
  logic [SIG_W-1:0]   sig_reg, sig_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SIG_W-1:0]   sig_out_reg, sig_out_next;
  logic               valid_reg, valid_next;

  // -------------------------------------------------------------------------
  // Fold: XOR of all SIG_W-bit chunks of the zero-padded input word.
  // Built as a prefix-XOR chain so each chunk is a visible stage.
  // -------------------------------------------------------------------------
  logic [NCHUNK*SIG_W-1:0]      y_pad;
  logic [NCHUNK:0][SIG_W-1:0]   fold_acc;
  logic [SIG_W-1:0]             fold;

  always_comb begin
    y_pad            = '0;
    y_pad[IN_W-1:0]  = y;
  end

  assign fold_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_fold
      assign fold_acc[gi+1] = fold_acc[gi] ^ y_pad[gi*SIG_W +: SIG_W];
    end
  endgenerate

  assign fold = fold_acc[NCHUNK];

  // -------------------------------------------------------------------------
  // MISR step and saturating counter increment.
  // X on y is deliberately not masked: it must show up in the signature.
  // -------------------------------------------------------------------------
  logic [SIG_W-1:0] misr_step;
  logic [CNT_W-1:0] cnt_inc;
  logic             auto_hit;

  assign misr_step = {sig_reg[SIG_W-2:0], 1'b0}
                   ^ (sig_reg[SIG_W-1] ? POLY : '0)
                   ^ fold;

  // Count sticks at all-ones; the signature keeps stepping regardless.
  assign cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

  // The sample being accepted this cycle brings the count to N_SAMPLES.
  assign auto_hit = (N_SAMPLES != 0) && (cnt_inc == CNT_W'(N_SAMPLES));

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sig_reg     <= SEED;
      cnt_reg     <= '0;
      sig_out_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sig_reg     <= sig_next;
      cnt_reg     <= cnt_next;
      sig_out_reg <= sig_out_next;
      valid_reg   <= valid_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-data logic
  // -------------------------------------------------------------------------
  logic [SIG_W-1:0] sig_acc;
  logic [CNT_W-1:0] cnt_acc;

  always_comb begin
    state_next   = state_reg;
    sig_next     = sig_reg;
    cnt_next     = cnt_reg;
    sig_out_next = sig_out_reg;
    valid_next   = valid_reg;
    sig_acc      = sample_en ? misr_step : sig_reg;
    cnt_acc      = sample_en ? cnt_inc   : cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          sig_next   = SEED;
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (start) begin
          // Restart wins over any sample or stop in the same cycle.
          sig_next = SEED;
          cnt_next = '0;
        end else begin
          sig_next = sig_acc;
          cnt_next = cnt_acc;
          // The same-cycle sample is already in sig_acc, so the published
          // signature includes it and appears one edge after the sample.
          if (stop || (sample_en && auto_hit)) begin
            state_next   = DONE;
            sig_out_next = sig_acc;
            valid_next   = 1'b1;
          end
        end
      end

      DONE: begin
        // Result holds until accepted; start alone cannot discard it.
        if (valid_reg && sig_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sig_out    = sig_out_reg;
  assign sample_cnt = cnt_reg;
  assign sig_valid  = valid_reg;
  assign busy       = (state_reg == RUN);

endmodule

// File: tb/tb_y_signature_compactor.sv
// ---------------------------------------------------------------------------
// tb_y_signature_compactor
//
// Directed bench for y_signature_compactor.  Instance dut uses the default
// parameters; instance dut_z uses SEED = 0, no auto-stop and a 4-bit counter
// to reach the zero-pad alignment and counter-saturation corner cases.
// ---------------------------------------------------------------------------
module tb_y_signature_compactor;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          rst, start, sample_en, stop, sig_ready;
  logic [480:0]  y;
  logic [31:0]   sig_out;
  logic [15:0]   sample_cnt;
  logic          sig_valid, busy;

  logic          rst_z, start_z, sample_en_z, stop_z, sig_ready_z;
  logic [480:0]  y_z;
  logic [31:0]   sig_out_z;
  logic [3:0]    sample_cnt_z;
  logic          sig_valid_z, busy_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y_signature_compactor dut (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .y(y),
    .stop(stop), .sig_out(sig_out), .sample_cnt(sample_cnt),
    .sig_valid(sig_valid), .sig_ready(sig_ready), .busy(busy)
  );

  y_signature_compactor #(
    .SEED(32'h00000000), .N_SAMPLES(0), .CNT_W(4)
  ) dut_z (
    .clk(clk), .rst(rst_z), .start(start_z), .sample_en(sample_en_z), .y(y_z),
    .stop(stop_z), .sig_out(sig_out_z), .sample_cnt(sample_cnt_z),
    .sig_valid(sig_valid_z), .sig_ready(sig_ready_z), .busy(busy_z)
  );

  // Reference MISR step: fold by bit position modulo 32.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [480:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 481; i++) f[i % 32] = f[i % 32] ^ v[i];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [480:0] vec(input int k);
    logic [511:0] t;
    for (int j = 0; j < 16; j++)
      t[j*32 +: 32] = (32'(k) * 32'h9E3779B9) ^ (32'(j) * 32'h01010101) ^ 32'h5A5A0F0F;
    return t[480:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_sig;

  initial begin
    rst = 1'b1; start = 1'b0; sample_en = 1'b0; stop = 1'b0; sig_ready = 1'b0; y = '0;
    rst_z = 1'b1; start_z = 1'b0; sample_en_z = 1'b0; stop_z = 1'b0; sig_ready_z = 1'b0; y_z = '0;
    tick();
    tick();

    // ---- Reset state ----
    chk("rst_sig_out", sig_out, 32'h0);
    chk("rst_cnt", 32'(sample_cnt), 32'h0);
    chk("rst_valid", 32'(sig_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    $display("reset: sig_out=%h cnt=%0d valid=%0b busy=%0b", sig_out, sample_cnt, sig_valid, busy);
    rst = 1'b0; rst_z = 1'b0;

    // ---- 1: single zero sample with stop ----
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_cnt0", 32'(sample_cnt), 32'h0);
    sample_en = 1'b1; y = '0; stop = 1'b1; tick();
    sample_en = 1'b0; stop = 1'b0;
    chk("t1_sig", sig_out, 32'hFB3EE249);
    chk("t1_cnt", 32'(sample_cnt), 32'h1);
    chk("t1_valid", 32'(sig_valid), 32'h1);
    chk("t1_busy_done", 32'(busy), 32'h0);
    $display("t1: sig_out=%h cnt=%0d valid=%0b", sig_out, sample_cnt, sig_valid);

    // ---- 4: hold in DONE with sig_ready low while toggling start/y ----
    for (int i = 0; i < 5; i++) begin
      start = i[0]; sample_en = 1'b1; stop = 1'b1; y = vec(100 + i);
      tick();
      chk("t4_hold_sig", sig_out, 32'hFB3EE249);
      chk("t4_hold_cnt", 32'(sample_cnt), 32'h1);
      chk("t4_hold_valid", 32'(sig_valid), 32'h1);
      $display("t4 hold %0d: sig_out=%h cnt=%0d valid=%0b", i, sig_out, sample_cnt, sig_valid);
    end
    start = 1'b0; sample_en = 1'b0; stop = 1'b0; y = '0;
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;
    chk("t4_valid_drop", 32'(sig_valid), 32'h0);
    chk("t4_busy_idle", 32'(busy), 32'h0);
    // IDLE must ignore sample_en / stop / sig_ready.
    sample_en = 1'b1; stop = 1'b1; sig_ready = 1'b1; y = vec(7); tick();
    sample_en = 1'b0; stop = 1'b0; sig_ready = 1'b0;
    chk("t4_idle_valid", 32'(sig_valid), 32'h0);
    chk("t4_idle_busy", 32'(busy), 32'h0);
    $display("t4 release: valid=%0b busy=%0b", sig_valid, busy);

    // ---- 3: auto-stop after 21 samples ----
    start = 1'b1; tick(); start = 1'b0;
    exp_sig = SEED;
    for (int k = 0; k < 21; k++) begin
      sample_en = 1'b1; y = vec(k);
      exp_sig = model_step(exp_sig, vec(k));
      tick();
      if (k == 19) begin
        chk("t3_valid_before", 32'(sig_valid), 32'h0);
        chk("t3_cnt20", 32'(sample_cnt), 32'd20);
        chk("t3_busy_before", 32'(busy), 32'h1);
      end
    end
    sample_en = 1'b0; y = '0;
    chk("t3_valid", 32'(sig_valid), 32'h1);
    chk("t3_cnt", 32'(sample_cnt), 32'd21);
    chk("t3_sig", sig_out, exp_sig);
    chk("t3_busy", 32'(busy), 32'h0);
    $display("t3: sig_out=%h expect=%h cnt=%0d", sig_out, exp_sig, sample_cnt);
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;
    chk("t3_release", 32'(sig_valid), 32'h0);

    // ---- 5: reset in RUN after 7 samples ----
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      sample_en = 1'b1; y = vec(40 + k); tick();
    end
    chk("t5_cnt7", 32'(sample_cnt), 32'd7);
    rst = 1'b1; stop = 1'b1; tick(); rst = 1'b0; stop = 1'b0; sample_en = 1'b0;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_cnt", 32'(sample_cnt), 32'h0);
    chk("t5_valid", 32'(sig_valid), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    sample_en = 1'b1; y = '0; stop = 1'b1; tick(); sample_en = 1'b0; stop = 1'b0;
    chk("t5_sig", sig_out, 32'hFB3EE249);
    chk("t5_cnt1", 32'(sample_cnt), 32'h1);
    $display("t5: sig_out=%h cnt=%0d", sig_out, sample_cnt);
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;

    // ---- 6: start in RUN with same-cycle sample ----
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_en = 1'b1; y = vec(60 + k); tick();
    end
    start = 1'b1; sample_en = 1'b1; y = vec(99); tick(); start = 1'b0;
    chk("t6_cnt", 32'(sample_cnt), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    exp_sig = SEED;
    for (int k = 0; k < 2; k++) begin
      sample_en = 1'b1; y = vec(70 + k); stop = (k == 1);
      exp_sig = model_step(exp_sig, vec(70 + k));
      tick();
    end
    sample_en = 1'b0; stop = 1'b0;
    chk("t6_sig", sig_out, exp_sig);
    chk("t6_cnt2", 32'(sample_cnt), 32'd2);
    $display("t6: sig_out=%h expect=%h cnt=%0d", sig_out, exp_sig, sample_cnt);
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;

    // ---- 2: SEED = 0, bit 0 and bit 480 alignment ----
    start_z = 1'b1; tick(); start_z = 1'b0;
    sample_en_z = 1'b1; y_z = '0; y_z[0] = 1'b1; stop_z = 1'b1; tick();
    sample_en_z = 1'b0; stop_z = 1'b0;
    chk("t2_bit0", sig_out_z, 32'h00000001);
    chk("t2_bit0_cnt", 32'(sample_cnt_z), 32'h1);
    $display("t2 bit0: sig_out=%h", sig_out_z);
    sig_ready_z = 1'b1; tick(); sig_ready_z = 1'b0;
    start_z = 1'b1; tick(); start_z = 1'b0;
    sample_en_z = 1'b1; y_z = '0; y_z[480] = 1'b1; stop_z = 1'b1; tick();
    sample_en_z = 1'b0; stop_z = 1'b0;
    chk("t2_bit480", sig_out_z, 32'h00000001);
    $display("t2 bit480: sig_out=%h", sig_out_z);
    sig_ready_z = 1'b1; tick(); sig_ready_z = 1'b0;

    // ---- counter saturation (4-bit counter, 17 samples) ----
    start_z = 1'b1; tick(); start_z = 1'b0;
    exp_sig = 32'h0;
    for (int k = 0; k < 17; k++) begin
      sample_en_z = 1'b1; y_z = vec(200 + k); stop_z = (k == 16);
      exp_sig = model_step(exp_sig, vec(200 + k));
      tick();
    end
    sample_en_z = 1'b0; stop_z = 1'b0;
    chk("sat_cnt", 32'(sample_cnt_z), 32'd15);
    chk("sat_sig", sig_out_z, exp_sig);
    chk("sat_valid", 32'(sig_valid_z), 32'h1);
    $display("sat: sig_out=%h expect=%h cnt=%0d", sig_out_z, exp_sig, sample_cnt_z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y_signature_compactor.md
Name: y_signature_compactor

Overview:
- Downstream consumer of the DUT output bus `y`.
- Compresses the per-cycle `y` word into a SIG_W-bit multiple-input signature register (MISR), so identity runs compare one signature instead of strobing 481-bit lines every cycle.
- Runs in the same clock domain as the DUT and samples `y` on posedge `clk`.
- Presents the final signature and sample count through a valid/ready handshake to the run checker.

Parameters:
- IN_W, 481: width of the sampled output bus `y` (`[480:0]`).
- SIG_W, 32: signature width.
- POLY, 32'h04C11DB7: MISR feedback polynomial; bit i set means a tap at bit i.
- SEED, 32'hFFFFFFFF: signature value loaded on `start`.
- N_SAMPLES, 21: auto-stop after this many accepted samples; 0 disables auto-stop.
- CNT_W, 16: sample counter width.

Ports:
- clk  input  1  sampling clock; rising edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load SEED, clear count, enter RUN.
- sample_en  input  1  qualifies `y` this cycle.
- y  input  IN_W  DUT output word.
- stop  input  1  end capture early.
- sig_out  output  SIG_W  final signature.
- sample_cnt  output  CNT_W  accepted samples.
- sig_valid  output  1  `sig_out` and `sample_cnt` are valid.
- sig_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN.

Behaviour:
- One clock; reset is synchronous and active-high, on ports `clk` / `rst`.
- Reset values:
  - state = IDLE
  - sig register = SEED
  - sig_out = 0
  - sample_cnt = 0
  - sig_valid = 0
  - busy = 0
- Reset overrides every other input in the same cycle, including mid-RUN and mid-DONE; any partial signature is discarded.
- Fold (combinational):
  - Zero-pad `y` to ceil(IN_W/SIG_W)*SIG_W bits (16 chunks for the defaults).
  - XOR all SIG_W chunks; chunk k = bits [k*SIG_W +: SIG_W].
- MISR step: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(y).
- States:
  - IDLE:
    - `start` loads sig = SEED, clears sample_cnt, goes to RUN, busy = 1 from the next cycle.
    - `sample_en`, `stop` and `sig_ready` are ignored.
  - RUN:
    - Each cycle with `sample_en` = 1 applies one MISR step and increments sample_cnt.
    - sample_cnt saturates at all-ones; the signature keeps stepping after saturation.
    - Exit to DONE when `stop` = 1, or when N_SAMPLES != 0 and the sample being accepted makes sample_cnt equal N_SAMPLES.
    - A sample and `stop` in the same cycle: the sample is folded in first, then the state moves to DONE.
    - `start` in RUN restarts: SEED is reloaded, count cleared, state stays RUN, and the same-cycle sample is dropped.
  - DONE:
    - On entry, sig_out = final signature and sig_valid = 1; busy = 0.
    - sig_out, sample_cnt and sig_valid hold stable until `sig_ready` = 1 is seen while sig_valid = 1.
    - On that handshake cycle: sig_valid falls on the next edge and state returns to IDLE.
    - `start` in DONE without `sig_ready` is ignored; the result must not be lost.
- Latency: the last sample to sig_valid is 1 cycle.
- sig_valid never asserts without a preceding `start`.
- X on `y` propagates into the signature unmasked; X detection is the checker's job.

Test Plan:
1. Reset, `start`, one sample with `y` = 0, `stop` in the same cycle -> next cycle sig_out = 32'hFB3EE249, sample_cnt = 1, sig_valid = 1.
2. Override SEED = 0; one sample with only `y[0]` = 1 -> sig_out = 32'h00000001. Repeat with only `y[480]` = 1 -> 32'h00000001 (verifies zero-pad and chunk 15 alignment).
3. N_SAMPLES = 21, `sample_en` held high, 21 testbench vectors applied -> sig_valid asserts exactly one cycle after the 21st sample; sample_cnt = 21; signature matches the bench reference model.
4. Hold `sig_ready` = 0 for 5 cycles in DONE while toggling `start` and `y` -> outputs unchanged. Raise `sig_ready` -> sig_valid = 0 the next cycle, state IDLE.
5. Assert `rst` in RUN after 7 samples -> next cycle busy = 0, sample_cnt = 0, sig_valid = 0. A new `start` plus 1 zero sample reproduces 32'hFB3EE249.
6. `start` in RUN after 3 samples, with a sample in the same cycle -> count = 0 afterwards; the signature equals a fresh run from SEED.
